bitpack_job_sched: RTL
======================

Name: bitpack_job_sched

Overview:
- Job scheduler placed in front of the bitstream-computing wrapper.
- Buffers (SRC, DST, SIZE) job descriptors from the control interface in a small FIFO.
- Launches them one at a time on the wrapper through its GO/DONE handshake, and holds the wrapper's SRC/DST/SIZE stable while each job runs.
- Reports progress: done counter, queue level, completion interrupt, sticky error for rejected jobs.

Parameters:
DEPTH, 4, descriptor FIFO entries; power of 2, ≥2
CNT_W, 16, width of completed-job counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
JOB_VALID  in  1  descriptor push request
JOB_READY  out  1  FIFO can accept descriptor
JOB_SRC  in  32  source address of descriptor
JOB_DST  in  32  destination address of descriptor
JOB_SIZE  in  32  bitstream length (cycles) of descriptor
RUN_EN  in  1  1 = launches allowed; 0 = hold queue (running job completes)
FLUSH  in  1  drop all queued, not-yet-launched descriptors
ERR_CLR  in  1  clear ERR_ZERO
W_GO  out  1  GO to wrapper
W_DONE  in  1  DONE from wrapper (1 = wrapper idle)
W_SRC  out  32  SRC to wrapper
W_DST  out  32  DST to wrapper
W_SIZE  out  32  SIZE to wrapper
BUSY  out  1  job running or queue non-empty
LEVEL  out  $clog2(DEPTH)+1  queued descriptor count
DONE_COUNT  out  CNT_W  completed jobs, wraps modulo 2^CNT_W
IRQ  out  1  one-cycle pulse: job finished and queue empty
ERR_ZERO  out  1  sticky: a SIZE==0 descriptor was discarded

Behaviour:
- Reset values:
  - all outputs 0, LEVEL 0, FIFO empty, state IDLE.
  - JOB_READY is 0 during reset, then 1 from the first cycle after.
- Push:
  - JOB_READY = (LEVEL != DEPTH) && !FLUSH. It does not depend on a same-cycle pop.
  - A push occurs on JOB_VALID && JOB_READY.
  - JOB_SIZE==0: descriptor is handshaken but discarded, ERR_ZERO set next cycle. Required because the wrapper would otherwise run 2^32 cycles.
  - Descriptor becomes visible (LEVEL updated) on the next cycle.
- FLUSH:
  - LEVEL←0 next cycle. Any descriptor popped in the same cycle is still launched.
- ERR_ZERO:
  - ERR_CLR clears it.
  - Simultaneous set and clear: set wins.
- FIFO: circular, pointer wrap modulo DEPTH. Push and pop in the same cycle leave LEVEL unchanged.
- State IDLE:
  - Transition when LEVEL>0 && RUN_EN && W_DONE && !FLUSH.
  - On transition: pop head, register it into W_SRC/W_DST/W_SIZE, go to LAUNCH.
  - W_DONE=0 (wrapper still finishing, e.g. after a scheduler-only reset) blocks any launch.
- State LAUNCH:
  - W_GO=1 for exactly this one cycle. W_DONE is 1 here by construction.
  - Next state: WAIT_ACK.
- State WAIT_ACK:
  - W_GO=0. Wait for W_DONE=0, meaning the wrapper left idle (normally 1 cycle).
  - Next state: WAIT_FIN.
- State WAIT_FIN:
  - On W_DONE=1: DONE_COUNT+1, then IRQ pulse that same cycle if LEVEL==0 and no push is registered that cycle.
  - Next state: IDLE.
- Wrapper protocol:
  - W_GO is dropped before the wrapper reaches its finish state, so the wrapper returns to idle by itself and W_DONE=1 marks completion.
  - W_SRC/W_DST/W_SIZE only change in the IDLE pop cycle; they are stable from LAUNCH through WAIT_FIN.
- Timing and status:
  - Minimum latency: push at cycle t into empty idle block → pop at t+1 → W_GO at t+2.
  - There is at least one IDLE cycle between consecutive jobs.
  - BUSY = (state!=IDLE) || (LEVEL!=0).
  - RUN_EN and FLUSH never abort a launched job.

Test Plan:
- Wrapper model (DONE drops 1 cycle after GO, rises 20 cycles later); push SRC=0x1000, DST=0x2000, SIZE=256 → W_GO single pulse 2 cycles after push, W_* hold those values until W_DONE=1, DONE_COUNT=1, one IRQ pulse.
- Push 3 jobs back-to-back → 3 W_GO pulses in FIFO order, each only after the previous W_DONE rise. IRQ only after job 3. DONE_COUNT=3.
- DEPTH=4, RUN_EN=0, push 6 → JOB_READY low after 4 accepted, LEVEL=4, no W_GO. RUN_EN=1 → jobs 1-4 launch in order.
- Push SIZE=0 between two valid jobs → ERR_ZERO=1, only 2 launches. ERR_CLR with no new zero job → ERR_ZERO=0.
- Queue 3 jobs, FLUSH while job 1 in WAIT_FIN → job 1 completes, LEVEL=0, no further W_GO, IRQ on job 1 finish.
- Reset scheduler while model W_DONE=0 with LEVEL>0 after reset → no W_GO until W_DONE=1. DONE_COUNT reset to 0. Wrap test: CNT_W=2, 5 jobs → DONE_COUNT=1.

Source files
------------

// File: rtl/bitpack_job_sched_if.sv
// Job scheduler bus: descriptor push, run control, status
// and the GO/DONE handshake toward the bitstream wrapper.
interface bitpack_job_sched_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          JOB_VALID;
  logic          JOB_READY;
  logic [31:0]   JOB_SRC;
  logic [31:0]   JOB_DST;
  logic [31:0]   JOB_SIZE;
  logic          RUN_EN;
  logic          FLUSH;
  logic          ERR_CLR;
  logic          W_GO;
  logic          W_DONE;
  logic [31:0]   W_SRC;
  logic [31:0]   W_DST;
  logic [31:0]   W_SIZE;
  logic          BUSY;
  logic [LW-1:0] LEVEL;
  logic [CNT_W-1:0] DONE_COUNT;
  logic          IRQ;
  logic          ERR_ZERO;

  modport master (
    output JOB_VALID, JOB_SRC, JOB_DST, JOB_SIZE,
    output RUN_EN, FLUSH, ERR_CLR, W_DONE,
    input  JOB_READY, W_GO, W_SRC, W_DST, W_SIZE,
    input  BUSY, LEVEL, DONE_COUNT, IRQ, ERR_ZERO
  );

  modport slave (
    input  JOB_VALID, JOB_SRC, JOB_DST, JOB_SIZE,
    input  RUN_EN, FLUSH, ERR_CLR, W_DONE,
    output JOB_READY, W_GO, W_SRC, W_DST, W_SIZE,
    output BUSY, LEVEL, DONE_COUNT, IRQ, ERR_ZERO
  );
endinterface

// File: rtl/bitpack_job_sched.sv
// Descriptor FIFO + launcher that runs one wrapper job
// at a time through the GO/DONE handshake.
module bitpack_job_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RST,
  bitpack_job_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] size;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE, LAUNCH, WAIT_ACK, WAIT_FIN
  } state_t;

  state_t        state_q, state_d;
  desc_t         mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q;
  logic          err_q;
  desc_t         cur_q;

  logic ready, push, push_store, pop;
  logic go, fin, irq;

  assign ready = !RST && (level_q != LW'(DEPTH))
              && !bus.FLUSH;
  assign push = bus.JOB_VALID && ready;
  assign push_store = push && (bus.JOB_SIZE != 32'd0);

  // Launch sequencing and completion detection
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    go = 1'b0;
    fin = 1'b0;
    irq = 1'b0;
    case (state_q)
      IDLE: begin
        if ((level_q != '0) && bus.RUN_EN
            && bus.W_DONE && !bus.FLUSH) begin
          pop = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        go = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.W_DONE) state_d = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (bus.W_DONE) begin
          fin = 1'b1;
          irq = (level_q == '0) && !push_store;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue occupancy; flush empties, push+pop cancels
  always_comb begin
    level_d = level_q;
    if (bus.FLUSH) begin
      level_d = '0;
    end else if (push_store && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push_store && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Control state, pointers, counters and wrapper args
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push_store) wr_q <= wr_q + PW'(1);
      if (bus.FLUSH) begin
        rd_q <= wr_q;
      end else if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      if (pop) cur_q <= mem_q[rd_q];
      if (fin) cnt_q <= cnt_q + CNT_W'(1);
      if (push && (bus.JOB_SIZE == 32'd0)) begin
        err_q <= 1'b1;
      end else if (bus.ERR_CLR) begin
        err_q <= 1'b0;
      end
    end
  end

  // Descriptor storage, written on accepted non-zero pushes
  always_ff @(posedge CLK) begin
    if (push_store) begin
      mem_q[wr_q] <= '{src:  bus.JOB_SRC,
                       dst:  bus.JOB_DST,
                       size: bus.JOB_SIZE};
    end
  end

  assign bus.JOB_READY  = ready;
  assign bus.W_GO       = go;
  assign bus.W_SRC      = cur_q.src;
  assign bus.W_DST      = cur_q.dst;
  assign bus.W_SIZE     = cur_q.size;
  assign bus.BUSY       = (state_q != IDLE) || (level_q != '0);
  assign bus.LEVEL      = level_q;
  assign bus.DONE_COUNT = cnt_q;
  assign bus.IRQ        = irq;
  assign bus.ERR_ZERO   = err_q;
endmodule
